// File: rtl/apple_pkg.sv
// apple_pkg: default geometry and timing constants shared by the
// apple eat detector. It also holds the flash FSM state type.
//   Constants: hit window x bounds, y tolerance above and below the bird,
//              respawn x position, default flash length.
//   Types:     flash_state_e (FLASH_IDLE / FLASH_ON).
package apple_pkg;

  localparam int HIT_X_LO_DEF     = 44;
  localparam int HIT_X_HI_DEF     = 50;
  localparam int Y_ABOVE_DEF      = 5;
  localparam int Y_BELOW_DEF      = 3;
  localparam int RESPAWN_X_DEF    = 170;
  localparam int FLASH_CYCLES_DEF = 8;

  typedef enum logic {
    FLASH_IDLE = 1'b0,
    FLASH_ON   = 1'b1
  } flash_state_e;

endpackage

// File: rtl/apple_hit_detect.sv
// apple_hit_detect: combinational hit test for one apple against the bird.
//   enable  in  game running
//   eaten   in  this apple is already eaten (cannot hit again)
//   x_apple in  apple x position
//   y_apple in  apple y position
//   y_bird  in  bird top row
//   hit     out apple is inside the bird's hitbox and eligible to be eaten
module apple_hit_detect #(
  parameter int X_W      = 9,
  parameter int Y_W      = 7,
  parameter int HIT_X_LO = 44,
  parameter int HIT_X_HI = 50,
  parameter int Y_ABOVE  = 5,
  parameter int Y_BELOW  = 3
) (
  input  logic           enable,
  input  logic           eaten,
  input  logic [X_W-1:0] x_apple,
  input  logic [Y_W-1:0] y_apple,
  input  logic [Y_W-1:0] y_bird,
  output logic           hit
);

  // Two guard bits so y+offset never wraps: a bird at row 0 or at the
  // bottom row must not alias with apples at the opposite screen edge.
  localparam int YE = Y_W + 2;

  logic [YE-1:0] y_a;
  logic [YE-1:0] y_b;
  logic          x_in;
  logic          y_in;

  always_comb begin
    y_a  = {2'b00, y_apple};
    y_b  = {2'b00, y_bird};
    x_in = (x_apple > X_W'(HIT_X_LO)) && (x_apple < X_W'(HIT_X_HI));
    y_in = ((y_a + YE'(Y_BELOW)) > y_b) && (y_a < (y_b + YE'(Y_ABOVE)));
    hit  = !eaten && enable && x_in && y_in;
  end

endmodule

// File: rtl/apple_collect.sv
// apple_collect: tracks N_APPLES apples against the bird's hitbox.
//   clk, reset   clock, asynchronous active-high reset
//   enable       game running; no new eats while low
//   score_clr    synchronous score clear
//   y_bird       bird top row
//   x_apple      packed apple x positions, apple i at [i*X_W +: X_W]
//   y_apple      packed apple y positions, apple i at [i*Y_W +: Y_W]
//   eaten        per-apple eaten flags
//   eat_pulse    one-cycle strobe per eat
//   eat_idx      index of the apple eaten, meaningful only with eat_pulse
//   score        saturating count of apples eaten
//   flash        high for FLASH_CYCLES clocks after the latest eat
//
// Output protocol: eat_pulse/eat_idx form a strobe with no backpressure.
// eat_idx is only defined in the cycle eat_pulse is high; consumers must
// capture it in that cycle, there is no ready to stall the detector.
module apple_collect
  import apple_pkg::*;
#(
  parameter int  N_APPLES     = 4,
  parameter int  X_W          = 9,
  parameter int  Y_W          = 7,
  parameter int  HIT_X_LO     = HIT_X_LO_DEF,
  parameter int  HIT_X_HI     = HIT_X_HI_DEF,
  parameter int  Y_ABOVE      = Y_ABOVE_DEF,
  parameter int  Y_BELOW      = Y_BELOW_DEF,
  parameter int  RESPAWN_X    = RESPAWN_X_DEF,
  parameter int  SCORE_W      = 10,
  parameter int  FLASH_CYCLES = FLASH_CYCLES_DEF,
  localparam int IDX_W        = (N_APPLES > 1) ? $clog2(N_APPLES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    score_clr,
  input  logic [Y_W-1:0]          y_bird,
  input  logic [N_APPLES*X_W-1:0] x_apple,
  input  logic [N_APPLES*Y_W-1:0] y_apple,
  output logic [N_APPLES-1:0]     eaten,
  output logic                    eat_pulse,
  output logic [IDX_W-1:0]        eat_idx,
  output logic [SCORE_W-1:0]      score,
  output logic                    flash
);

  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  logic [N_APPLES-1:0] hit;
  logic [N_APPLES-1:0] respawn;
  logic [N_APPLES-1:0] win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                any_hit;
  logic                eat_now;
  logic [N_APPLES-1:0] eaten_nxt;

  flash_state_e        flash_state, flash_state_nxt;
  logic [FLASH_W-1:0]  flash_cnt, flash_cnt_nxt;

  for (genvar g = 0; g < N_APPLES; g++) begin : g_apple
    apple_hit_detect #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .HIT_X_LO (HIT_X_LO),
      .HIT_X_HI (HIT_X_HI),
      .Y_ABOVE  (Y_ABOVE),
      .Y_BELOW  (Y_BELOW)
    ) u_hit (
      .enable  (enable),
      .eaten   (eaten[g]),
      .x_apple (x_apple[g*X_W +: X_W]),
      .y_apple (y_apple[g*Y_W +: Y_W]),
      .y_bird  (y_bird),
      .hit     (hit[g])
    );
    assign respawn[g] = (x_apple[g*X_W +: X_W] == X_W'(RESPAWN_X));
  end

  // Lowest index wins; losers are still un-eaten and retry next cycle.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_hit = 1'b0;
    for (int i = 0; i < N_APPLES; i++) begin
      if (hit[i] && !any_hit) begin
        any_hit   = 1'b1;
        win_oh[i] = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    // A respawning winner cancels the whole eat: no pulse, no score,
    // and the lower-priority hits are not promoted this cycle.
    eat_now   = any_hit && !(|(win_oh & respawn));
    eaten_nxt = (eaten | (eat_now ? win_oh : '0)) & ~respawn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eaten     <= '0;
      eat_pulse <= 1'b0;
      eat_idx   <= '0;
      score     <= '0;
    end else begin
      eaten     <= eaten_nxt;
      eat_pulse <= eat_now;
      if (eat_now) eat_idx <= win_idx;
      if (score_clr)                       score <= '0;
      else if (eat_now && (score != '1))   score <= score + 1'b1;
    end
  end

  // Flash FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_state <= FLASH_IDLE;
      flash_cnt   <= '0;
    end else begin
      flash_state <= flash_state_nxt;
      flash_cnt   <= flash_cnt_nxt;
    end
  end

  // Flash FSM: next state. cnt holds remaining cycles after the current one.
  always_comb begin
    flash_state_nxt = flash_state;
    flash_cnt_nxt   = flash_cnt;
    case (flash_state)
      FLASH_IDLE: begin
        if (eat_now) begin
          flash_state_nxt = FLASH_ON;
          flash_cnt_nxt   = FLASH_W'(FLASH_CYCLES - 1);
        end
      end
      FLASH_ON: begin
        if (eat_now) begin
          flash_cnt_nxt = FLASH_W'(FLASH_CYCLES - 1);
        end else if (flash_cnt == '0) begin
          flash_state_nxt = FLASH_IDLE;
        end else begin
          flash_cnt_nxt = flash_cnt - 1'b1;
        end
      end
      default: flash_state_nxt = FLASH_IDLE;
    endcase
  end

  assign flash = (flash_state == FLASH_ON);

endmodule

// File: tb/tb_apple_collect.sv
// tb_apple_collect: directed bench for apple_collect with a behavioural
// model and a per-cycle compare, plus literal checks at key points.
module tb_apple_collect;

  localparam int N   = 4;
  localparam int XW  = 9;
  localparam int YW  = 7;
  localparam int SW  = 3;
  localparam int FL  = 8;
  localparam int XLO = 44;
  localparam int XHI = 50;
  localparam int YAB = 5;
  localparam int YBE = 3;
  localparam int RSP = 170;
  localparam int SMAX = (1 << SW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              enable;
  logic              score_clr;
  logic [YW-1:0]     y_bird;
  logic [N*XW-1:0]   x_apple;
  logic [N*YW-1:0]   y_apple;

  logic [N-1:0]      eaten;
  logic              eat_pulse;
  logic [1:0]        eat_idx;
  logic [SW-1:0]     score;
  logic              flash;

  logic [N-1:0]      r_eaten;
  logic              r_eat_pulse;
  logic [1:0]        r_eat_idx;
  logic [9:0]        r_score;
  logic              r_flash;

  apple_collect #(.N_APPLES(N), .X_W(XW), .Y_W(YW), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .score_clr(score_clr),
    .y_bird(y_bird), .x_apple(x_apple), .y_apple(y_apple),
    .eaten(eaten), .eat_pulse(eat_pulse), .eat_idx(eat_idx),
    .score(score), .flash(flash)
  );

  // Second instance whose respawn column sits inside the hit window, so an
  // eat and a respawn of the same apple can coincide.
  apple_collect #(.N_APPLES(N), .X_W(XW), .Y_W(YW), .RESPAWN_X(47)) dut_r (
    .clk(clk), .reset(reset), .enable(enable), .score_clr(score_clr),
    .y_bird(y_bird), .x_apple(x_apple), .y_apple(y_apple),
    .eaten(r_eaten), .eat_pulse(r_eat_pulse), .eat_idx(r_eat_idx),
    .score(r_score), .flash(r_flash)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int x_of(input logic [N*XW-1:0] xv, input int i);
    return int'(xv[i*XW +: XW]);
  endfunction

  function automatic int y_of(input logic [N*YW-1:0] yv, input int i);
    return int'(yv[i*YW +: YW]);
  endfunction

  function automatic bit in_window(input int x, input int y, input int yb);
    return (x > XLO) && (x < XHI) && (y + YBE > yb) && (y < yb + YAB);
  endfunction

  logic [N-1:0] m_eaten;
  logic         m_pulse;
  int           m_idx;
  int           m_score;
  int           m_flash_left;
  int           m_k;
  logic         m_eat;
  logic [N-1:0] m_resp;

  always_comb begin
    m_k    = -1;
    m_resp = '0;
    m_eat  = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_resp[i] = (x_of(x_apple, i) == RSP);
      if (m_k < 0 && !m_eaten[i] && enable &&
          in_window(x_of(x_apple, i), y_of(y_apple, i), int'(y_bird)))
        m_k = i;
    end
    if (m_k >= 0) m_eat = !m_resp[m_k];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_eaten      <= '0;
      m_pulse      <= 1'b0;
      m_idx        <= 0;
      m_score      <= 0;
      m_flash_left <= 0;
    end else begin
      m_pulse <= m_eat;
      if (m_eat) m_idx <= m_k;
      for (int i = 0; i < N; i++) begin
        if (m_resp[i])              m_eaten[i] <= 1'b0;
        else if (m_eat && m_k == i) m_eaten[i] <= 1'b1;
      end
      if (score_clr)                      m_score <= 0;
      else if (m_eat && m_score < SMAX)   m_score <= m_score + 1;
      if (m_eat)                  m_flash_left <= FL;
      else if (m_flash_left > 0)  m_flash_left <= m_flash_left - 1;
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (!reset && cmp_en) begin
      chk("cmp_eaten", int'(eaten), int'(m_eaten));
      chk("cmp_eat_pulse", int'(eat_pulse), int'(m_pulse));
      chk("cmp_score", int'(score), m_score);
      chk("cmp_flash", int'(flash), int'(m_flash_left > 0));
      if (m_pulse) chk("cmp_eat_idx", int'(eat_idx), m_idx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_apple(input int i, input int x, input int y);
    x_apple[i*XW +: XW] = XW'(x);
    y_apple[i*YW +: YW] = YW'(y);
  endtask

  task automatic set_x(input int i, input int x);
    x_apple[i*XW +: XW] = XW'(x);
  endtask

  task automatic count_flash(input int start, output int n);
    n = start;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (flash) n++;
      else break;
    end
  endtask

  task automatic wait_flash_idle();
    for (int j = 0; j < 30 && flash; j++) tick();
    chk("flash_idle_wait", int'(flash), 0);
  endtask

  // ---------------- stimulus ----------------
  int nf;

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    score_clr = 1'b0;
    y_bird    = 7'd40;
    x_apple   = '0;
    y_apple   = '0;
    for (int i = 0; i < N; i++) set_apple(i, 100, 0);
    tick();
    tick();
    chk("reset_eaten", int'(eaten), 0);
    chk("reset_eat_pulse", int'(eat_pulse), 0);
    chk("reset_eat_idx", int'(eat_idx), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_flash", int'(flash), 0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Single eat and flash length
    set_apple(0, 47, 42);
    tick();
    chk("eat0_eaten", int'(eaten), 4'b0001);
    chk("eat0_pulse", int'(eat_pulse), 1);
    chk("eat0_idx", int'(eat_idx), 0);
    chk("eat0_score", int'(score), 1);
    chk("eat0_flash", int'(flash), 1);
    chk("respawn_wins_pulse", int'(r_eat_pulse), 0);
    chk("respawn_wins_eaten", int'(r_eaten), 0);
    chk("respawn_wins_score", int'(r_score), 0);
    chk("respawn_wins_flash", int'(r_flash), 0);
    chk("respawn_wins_idx", int'(r_eat_idx), 0);
    set_x(0, 100);
    count_flash(1, nf);
    chk("flash_len_single", nf, 8);

    // Two apples in the window together: lowest index first
    set_apple(1, 46, 40);
    set_apple(2, 46, 40);
    tick();
    chk("prio_idx_first", int'(eat_idx), 1);
    chk("prio_pulse_first", int'(eat_pulse), 1);
    tick();
    chk("prio_idx_second", int'(eat_idx), 2);
    chk("prio_pulse_second", int'(eat_pulse), 1);
    chk("prio_score", int'(score), 3);
    set_x(1, 100);
    set_x(2, 100);
    tick();

    // No wrap on the y compare
    y_bird = 7'd0;
    set_apple(3, 47, 126);
    tick();
    chk("nowrap_top_far", int'(eat_pulse), 0);
    set_apple(3, 47, 2);
    tick();
    chk("nowrap_top_hit", int'(eat_pulse), 1);
    chk("nowrap_top_idx", int'(eat_idx), 3);
    chk("nowrap_top_eaten", int'(eaten), 4'b1111);
    set_x(3, RSP);
    tick();
    chk("respawn_clear", int'(eaten), 4'b0111);
    set_apple(3, 47, 5);
    tick();
    chk("y_above_bound", int'(eat_pulse), 0);
    y_bird = 7'd126;
    set_apple(3, 47, 127);
    tick();
    chk("nowrap_bottom_hit", int'(eat_pulse), 1);
    chk("nowrap_bottom_score", int'(score), 5);

    // Saturation and score_clr
    for (int i = 0; i < N; i++) set_x(i, RSP);
    tick();
    chk("respawn_all", int'(eaten), 0);
    y_bird = 7'd40;
    for (int i = 0; i < N; i++) set_apple(i, 47, 42);
    tick(); tick(); tick(); tick();
    chk("sat_score", int'(score), 7);
    chk("sat_eaten", int'(eaten), 4'b1111);
    set_x(0, RSP);
    tick();
    set_x(0, 47);
    score_clr = 1'b1;
    tick();
    score_clr = 1'b0;
    chk("clr_wins_score", int'(score), 0);
    chk("clr_wins_pulse", int'(eat_pulse), 1);

    // enable low blocks eats
    set_x(0, RSP);
    tick();
    set_x(0, 47);
    enable = 1'b0;
    tick();
    chk("disabled_pulse", int'(eat_pulse), 0);
    chk("disabled_eaten", int'(eaten), 4'b1110);
    enable = 1'b1;
    tick();
    chk("enabled_pulse", int'(eat_pulse), 1);
    chk("enabled_score", int'(score), 1);

    // Flash reload: second eat three cycles after the first
    set_x(0, RSP);
    set_x(1, RSP);
    tick();
    wait_flash_idle();
    set_x(0, 47);
    tick();
    set_x(0, 100);
    nf = 1;
    tick(); if (flash) nf++;
    tick(); if (flash) nf++;
    set_x(1, 47);
    tick();
    if (flash) nf++;
    set_x(1, 100);
    count_flash(nf, nf);
    chk("flash_len_reload", nf, 11);

    // Reset in the middle of a flash
    set_x(0, RSP);
    tick();
    set_x(0, 47);
    tick();
    tick();
    chk("pre_reset_flash", int'(flash), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_flash", int'(flash), 0);
    chk("async_reset_eaten", int'(eaten), 0);
    chk("async_reset_score", int'(score), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
